// File: rtl/pdm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_pkg: shared PDM peripheral constants and register map.  Rev 1.0
// ---------------------------------------------------------------------------
package pdm_pkg;

  localparam int PDM_PCM_W      = 16;
  localparam int PDM_FIFO_DEPTH = 8;

  // Byte offsets of the FIFO-facing registers in the peripheral map
  localparam logic [7:0] PDM_REG_FIFO_DATA = 8'h0C;
  localparam logic [7:0] PDM_REG_STATUS    = 8'h10;
  localparam logic [7:0] PDM_REG_THRESH    = 8'h14;

  function automatic int pdm_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_fifo_mem: DEPTH x WIDTH register array, sync write / async read.  Rev 1.0
// ---------------------------------------------------------------------------
module pdm_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pdm_pcm_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_pcm_fifo: FWFT PCM sample buffer with level irq and sticky flags.  Rev 1.0
// ---------------------------------------------------------------------------
module pdm_pcm_fifo
  import pdm_pkg::*;
#(
  parameter int DEPTH = PDM_FIFO_DEPTH,
  parameter int WIDTH = PDM_PCM_W,
  parameter int LVL_W = pdm_lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] pcm_in,
  input  logic             pcm_valid,
  input  logic             pop,
  input  logic [LVL_W-1:0] thresh,
  input  logic             ovf_clr,
  input  logic             unf_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             irq
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic             valid_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic [WIDTH-1:0] head_data;
  logic             push_req;
  logic             flush_all;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             unf_set;

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign rd_data = empty ? '0 : head_data;

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle
  always_comb begin
    push_req  = pcm_valid & ~valid_q & enable;
    flush_all = flush | ~enable;
    do_pop    = pop & ~empty & ~flush_all;
    do_push   = push_req & (~full | pop) & ~flush_all;
    ovf_set   = push_req & full & ~pop & ~flush_all;
    unf_set   = pop & empty & ~flush_all;
    level_nxt = level;
    if (flush_all) begin
      level_nxt = '0;
    end else if (do_push && !do_pop) begin
      level_nxt = level + 1'b1;
    end else if (do_pop && !do_push) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq       <= 1'b0;
    end else begin
      valid_q <= pcm_valid;
      if (flush_all) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level     <= level_nxt;
      overflow  <= ovf_set | (overflow & ~ovf_clr);
      underflow <= unf_set | (underflow & ~unf_clr);
      irq       <= (thresh != '0) && (level_nxt >= thresh);
    end
  end

  pdm_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (pcm_in),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pdm_pcm_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pdm_pcm_fifo: scenario and randomized bench for pdm_pcm_fifo.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_pdm_pcm_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int LVL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             flush;
  logic [WIDTH-1:0] pcm_in;
  logic             pcm_valid;
  logic             pop;
  logic [LVL_W-1:0] thresh;
  logic             ovf_clr;
  logic             unf_clr;
  logic [WIDTH-1:0] rd_data;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             irq;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue plus flag bits
  logic [WIDTH-1:0] q[$];
  bit m_ovf, m_unf, m_irq, m_vq;

  pdm_pcm_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LVL_W(LVL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .pcm_in    (pcm_in),
    .pcm_valid (pcm_valid),
    .pop       (pop),
    .thresh    (thresh),
    .ovf_clr   (ovf_clr),
    .unf_clr   (unf_clr),
    .rd_data   (rd_data),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    bit preq, fl;
    int n;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_irq = 0; m_vq = 0;
      return;
    end
    preq = pcm_valid && !m_vq && enable;
    fl   = flush || !enable;
    if (ovf_clr) m_ovf = 0;
    if (unf_clr) m_unf = 0;
    if (fl) begin
      q.delete();
    end else begin
      n = q.size();
      if (preq && n == DEPTH && !pop) m_ovf = 1;
      if (pop && n == 0) m_unf = 1;
      if (pop && n > 0) void'(q.pop_front());
      if (preq && q.size() < DEPTH) q.push_back(pcm_in);
    end
    m_irq = (thresh != 0) && (q.size() >= int'(thresh));
    m_vq  = pcm_valid;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [WIDTH-1:0] d);
    pcm_in = d; pcm_valid = 1'b1; cyc();
    pcm_valid = 1'b0; cyc();
  endtask

  task automatic pop_one();
    pop = 1'b1; cyc(); pop = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; cyc(); flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    total++; if (level !== 0)     begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin bad++; $display("FAIL reset_flags got=%b%b want=00", overflow, underflow); end
    total++; if (irq !== 1'b0)    begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (rd_data !== 0)   begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
  endtask

  task automatic test_single_push();
    enable = 1'b1; thresh = '0; cyc();
    pcm_in = 16'h1234; pcm_valid = 1'b1; cyc();
    total++; if (level !== 1)        begin bad++; $display("FAIL single_level got=%0d want=1", level); end
    total++; if (rd_data !== 16'h1234) begin bad++; $display("FAIL single_data got=%h want=1234", rd_data); end
    for (int i = 0; i < 39; i++) begin
      cyc();
      total++; if (level !== 1 || irq !== 1'b0)
        begin bad++; $display("FAIL held_valid cyc=%0d level=%0d irq=%b want level=1 irq=0", i, level, irq); end
    end
    pcm_valid = 1'b0; cyc();
    do_flush();
  endtask

  task automatic test_threshold();
    thresh = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      pcm_in = WIDTH'(i); pcm_valid = 1'b1; cyc();
      total++; if (level !== LVL_W'(i) || irq !== (i == 4))
        begin bad++; $display("FAIL thresh_push i=%0d level=%0d irq=%b want level=%0d irq=%b", i, level, irq, i, i == 4); end
      pcm_valid = 1'b0; cyc();
    end
    for (int i = 1; i <= 4; i++) begin
      total++; if (rd_data !== WIDTH'(i))
        begin bad++; $display("FAIL thresh_pop_data i=%0d got=%h want=%h", i, rd_data, i); end
      pop_one();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL thresh_irq_drop i=%0d got=%b want=0", i, irq); end
    end
    total++; if (empty !== 1'b1 || rd_data !== 0)
      begin bad++; $display("FAIL thresh_drained empty=%b rd=%h want empty=1 rd=0", empty, rd_data); end
    thresh = '0;
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp;
    for (int i = 1; i <= 9; i++) push_sample(WIDTH'(16'hA000 + i));
    total++; if (full !== 1'b1 || level !== 8)
      begin bad++; $display("FAIL ovf_full full=%b level=%0d want full=1 level=8", full, level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    pcm_in = 16'hB000; pcm_valid = 1'b1; pop = 1'b1; cyc();
    pcm_valid = 1'b0; pop = 1'b0;
    total++; if (level !== 8 || overflow !== 1'b0)
      begin bad++; $display("FAIL ovf_pushpop level=%0d ovf=%b want level=8 ovf=0", level, overflow); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? WIDTH'(16'hA002 + i) : 16'hB000;
      total++; if (rd_data !== exp) begin bad++; $display("FAIL ovf_drain i=%0d got=%h want=%h", i, rd_data, exp); end
      pop_one();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drained empty=%b want=1", empty); end
  endtask

  task automatic test_underflow();
    do_flush();
    pop_one();
    total++; if (underflow !== 1'b1 || level !== 0)
      begin bad++; $display("FAIL unf_set unf=%b level=%0d want unf=1 level=0", underflow, level); end
    unf_clr = 1'b1; cyc(); unf_clr = 1'b0;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b want=0", underflow); end
    pcm_in = 16'hBEEF; pcm_valid = 1'b1; pop = 1'b1; cyc();
    pcm_valid = 1'b0; pop = 1'b0;
    total++; if (level !== 1 || rd_data !== 16'hBEEF || underflow !== 1'b1)
      begin bad++; $display("FAIL unf_pushpop level=%0d rd=%h unf=%b want 1 beef 1", level, rd_data, underflow); end
    cyc();
    do_flush();
    unf_clr = 1'b1; cyc(); unf_clr = 1'b0;
  endtask

  task automatic test_enable_flush();
    thresh = 4'd3;
    for (int i = 1; i <= 4; i++) push_sample(WIDTH'(16'hC000 + i));
    pcm_in = 16'hC005; pcm_valid = 1'b1; cyc(); cyc();
    total++; if (level !== 5 || irq !== 1'b1)
      begin bad++; $display("FAIL en_fill level=%0d irq=%b want level=5 irq=1", level, irq); end
    enable = 1'b0; cyc();
    total++; if (level !== 0 || irq !== 1'b0)
      begin bad++; $display("FAIL en_flush level=%0d irq=%b want level=0 irq=0", level, irq); end
    enable = 1'b1; cyc(); cyc();
    total++; if (level !== 0) begin bad++; $display("FAIL en_no_spurious level=%0d want=0", level); end
    pcm_valid = 1'b0; cyc();
    pcm_in = 16'hC006; pcm_valid = 1'b1; cyc();
    total++; if (level !== 1 || rd_data !== 16'hC006)
      begin bad++; $display("FAIL en_repush level=%0d rd=%h want 1 c006", level, rd_data); end
    pcm_valid = 1'b0; cyc();
    thresh = '0;
    do_flush();
  endtask

  task automatic test_wrap();
    int occ, nw, nr;
    bit do_push;
    logic [WIDTH-1:0] exp;
    ovf_clr = 1'b1; unf_clr = 1'b1; cyc(); ovf_clr = 1'b0; unf_clr = 1'b0;
    occ = 0; nw = 0; nr = 0;
    while (nr < 20) begin
      if (occ == 0)                       do_push = 1;
      else if (occ == DEPTH || nw >= 20)  do_push = 0;
      else if (nw < DEPTH)                do_push = 1;
      else                                do_push = ($urandom_range(1, 0) == 1);
      if (do_push) begin
        push_sample(WIDTH'(16'h5000 + nw));
        nw++; occ++;
      end else begin
        exp = WIDTH'(16'h5000 + nr);
        total++; if (rd_data !== exp) begin bad++; $display("FAIL wrap_data n=%0d got=%h want=%h", nr, rd_data, exp); end
        pop_one();
        nr++; occ--;
      end
    end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1)
      begin bad++; $display("FAIL wrap_end ovf=%b unf=%b empty=%b want 0 0 1", overflow, underflow, empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_sample(WIDTH'(16'h7700 + i));
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    total++; if (level !== 0 || empty !== 1'b1 || rd_data !== 0)
      begin bad++; $display("FAIL reset_mid level=%0d empty=%b rd=%h want 0 1 0", level, empty, rd_data); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_rd;
    int pop_pct;
    for (int i = 0; i < 400; i++) begin
      pop_pct   = (i < 200) ? 12 : 45;
      rst_n     = ($urandom_range(99, 0) != 0);
      enable    = ($urandom_range(24, 0) != 0);
      flush     = ($urandom_range(39, 0) == 0);
      pop       = ($urandom_range(99, 0) < pop_pct);
      ovf_clr   = ($urandom_range(9, 0) == 0);
      unf_clr   = ($urandom_range(9, 0) == 0);
      pcm_in    = WIDTH'($urandom);
      if ($urandom_range(9, 0) < 5) pcm_valid = ~pcm_valid;
      if ($urandom_range(15, 0) == 0) thresh = LVL_W'($urandom_range(DEPTH, 0));
      cyc();
      exp_rd = (q.size() > 0) ? q[0] : '0;
      total++; if (level !== LVL_W'(q.size()))
        begin bad++; $display("FAIL rnd_level i=%0d got=%0d want=%0d", i, level, q.size()); end
      total++; if (rd_data !== exp_rd)
        begin bad++; $display("FAIL rnd_rd_data i=%0d got=%h want=%h", i, rd_data, exp_rd); end
      total++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH))
        begin bad++; $display("FAIL rnd_empty_full i=%0d got=%b%b want=%b%b", i, empty, full, q.size() == 0, q.size() == DEPTH); end
      total++; if (overflow !== m_ovf || underflow !== m_unf)
        begin bad++; $display("FAIL rnd_flags i=%0d got=%b%b want=%b%b", i, overflow, underflow, m_ovf, m_unf); end
      total++; if (irq !== m_irq)
        begin bad++; $display("FAIL rnd_irq i=%0d got=%b want=%b", i, irq, m_irq); end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; pcm_in = '0; pcm_valid = 1'b0;
    pop = 1'b0; thresh = '0; ovf_clr = 1'b0; unf_clr = 1'b0;
    test_reset();
    test_single_push();
    test_threshold();
    test_overflow();
    test_underflow();
    test_enable_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
